// File: rtl/hdmi_audio_pacer_if.sv
// Sample bus between the audio pacer, the core's PCM source and hdmi_tx.
interface hdmi_audio_pacer_if #(
  parameter int NCH   = 2,
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
);
  logic [NCH*IN_W-1:0]  pcm_in;
  logic                 pcm_fs;
  logic [NCH*OUT_W-1:0] pcm_out;
  logic                 sample_stb;

  modport master (input pcm_in, output pcm_fs, pcm_out, sample_stb);
  modport slave  (output pcm_in, input pcm_fs, pcm_out, sample_stb);
endinterface

// File: rtl/hdmi_audio_pacer.sv
// HDMI audio pacer: fractional-N pcm_fs generator plus a glitch-checked,
// gain-shifted and saturated PCM capture from the asynchronous core domain.
module hdmi_audio_pacer_lane #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 24,
  parameter int GAIN_SHIFT = 5
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o
);
  localparam int XW = IN_W + GAIN_SHIFT + 1;
  localparam int CW = ((XW > OUT_W) ? XW : OUT_W) + 1;
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [XW-1:0] x;
  logic signed [CW-1:0] xe;

  assign x  = $signed({{(GAIN_SHIFT+1){din_i[IN_W-1]}}, din_i}) <<< GAIN_SHIFT;
  assign xe = CW'(x);

  always_comb begin
    if (xe > MAXV)      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
    else if (xe < MINV) dout_o = {1'b1, {(OUT_W-1){1'b0}}};
    else                dout_o = xe[OUT_W-1:0];
  end
endmodule

module hdmi_audio_pacer #(
  parameter int NCH        = 2,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 24,
  parameter int GAIN_SHIFT = 5,
  parameter int ACC_W      = 18,
  parameter int ADD0       = 8,
  parameter int MAX0       = 3125,
  parameter int ADD1       = 441,
  parameter int MAX1       = 125000,
  parameter int ADD2       = 12,
  parameter int MAX2       = 3125,
  parameter int RATE_INIT  = 0
) (
  input  logic                pixel_clk,
  input  logic                sys_reset_125,
  input  logic [1:0]          rate_sel,
  input  logic                mute,
  output logic [1:0]          rate_cur,
  output logic                rate_err,
  output logic                capture_miss,
  hdmi_audio_pacer_if.master  bus
);
  localparam logic [1:0] RATE_RST = 2'(RATE_INIT);

  function automatic logic [ACC_W-1:0] add_of(input logic [1:0] r);
    case (r)
      2'd1:    return ACC_W'(ADD1);
      2'd2:    return ACC_W'(ADD2);
      default: return ACC_W'(ADD0);
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] max_of(input logic [1:0] r);
    case (r)
      2'd1:    return ACC_W'(MAX1);
      2'd2:    return ACC_W'(MAX2);
      default: return ACC_W'(MAX0);
    endcase
  endfunction

  typedef enum logic {IDLE, PEND} state_t;

  logic [1:0]                       rsel_s1_q, rsel_s2_q;
  logic                             mute_s1_q, mute_s2_q;
  logic [NCH-1:0][IN_W-1:0]         pcm_a_q, pcm_b_q;
  logic [NCH-1:0][OUT_W-1:0]        conv, out_q;
  logic [ACC_W-1:0]                 count_q, count_d, sa;
  logic [1:0]                       rate_q, rate_d;
  logic                             err_q, err_d;
  logic                             fs_q, miss_q, stb_q;
  logic                             evt, fall, rise;
  state_t                           st_q;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    hdmi_audio_pacer_lane #(
      .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT)
    ) u_lane (
      .din_i (pcm_b_q[g]),
      .dout_o(conv[g])
    );
  end

  // A non-negative remainder is an event; the step after a falling event
  // already uses the newly selected rate so the switch is seamless.
  always_comb begin
    sa     = count_q - max_of(rate_q);
    evt    = ~sa[ACC_W-1];
    fall   = evt & fs_q;
    rise   = evt & ~fs_q;
    rate_d = rate_q;
    err_d  = err_q;
    if (fall) begin
      if (rsel_s2_q == 2'd3) err_d  = 1'b1;
      else                   rate_d = rsel_s2_q;
    end
    count_d = evt ? sa + add_of(rate_d) : count_q + add_of(rate_q);
  end

  always_ff @(posedge pixel_clk or posedge sys_reset_125) begin
    if (sys_reset_125) begin
      rsel_s1_q <= '0;
      rsel_s2_q <= '0;
      mute_s1_q <= 1'b0;
      mute_s2_q <= 1'b0;
      pcm_a_q   <= '0;
      pcm_b_q   <= '0;
      count_q   <= '0;
      fs_q      <= 1'b0;
      rate_q    <= RATE_RST;
      err_q     <= 1'b0;
    end else begin
      rsel_s1_q <= rate_sel;
      rsel_s2_q <= rsel_s1_q;
      mute_s1_q <= mute;
      mute_s2_q <= mute_s1_q;
      pcm_a_q   <= bus.pcm_in;
      pcm_b_q   <= pcm_a_q;
      count_q   <= count_d;
      rate_q    <= rate_d;
      err_q     <= err_d;
      if (evt) fs_q <= ~fs_q;
    end
  end

  // Capture window is the low phase; a rising event ends it unconditionally
  // so pcm_out never changes while pcm_fs is high.
  always_ff @(posedge pixel_clk or posedge sys_reset_125) begin
    if (sys_reset_125) begin
      st_q   <= IDLE;
      out_q  <= '0;
      stb_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (st_q)
        IDLE: if (fall) st_q <= PEND;
        PEND: begin
          if (rise) begin
            miss_q <= 1'b1;
            st_q   <= IDLE;
          end else if (pcm_a_q == pcm_b_q) begin
            out_q <= mute_s2_q ? '0 : conv;
            stb_q <= 1'b1;
            st_q  <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.pcm_fs     = fs_q;
  assign bus.pcm_out    = out_q;
  assign bus.sample_stb = stb_q;
  assign rate_cur       = rate_q;
  assign rate_err       = err_q;
  assign capture_miss   = miss_q;
endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// Self-checking bench: default-parameter pacer plus a saturating variant
// (OUT_W=16, GAIN_SHIFT=2) driven from a vector table.
module tb_hdmi_audio_pacer;
  logic       pixel_clk = 1'b0;
  logic       rst;
  logic [1:0] rate_sel, rate_cur, rate_sel2, rate_cur2;
  logic       mute, rate_err, capture_miss, mute2, rate_err2, capture_miss2;

  always #20 pixel_clk = ~pixel_clk;

  hdmi_audio_pacer_if #(.NCH(2), .IN_W(16), .OUT_W(24)) bus1();
  hdmi_audio_pacer_if #(.NCH(2), .IN_W(16), .OUT_W(16)) bus2();

  hdmi_audio_pacer u_dut (
    .pixel_clk(pixel_clk), .sys_reset_125(rst), .rate_sel(rate_sel), .mute(mute),
    .rate_cur(rate_cur), .rate_err(rate_err), .capture_miss(capture_miss), .bus(bus1.master)
  );

  hdmi_audio_pacer #(.OUT_W(16), .GAIN_SHIFT(2)) u_sat (
    .pixel_clk(pixel_clk), .sys_reset_125(rst), .rate_sel(rate_sel2), .mute(mute2),
    .rate_cur(rate_cur2), .rate_err(rate_err2), .capture_miss(capture_miss2), .bus(bus2.master)
  );

  typedef struct { logic [15:0] i0, i1, e0, e1; } vec_t;
  vec_t tbl [5];

  int  n_chk = 0, n_pass = 0, stb_cnt = 0;
  bit  fs_prev = 1'b0, fell, rose, tog, stb2, glitch = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: event not seen within cycle budget", nm);
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    fell    = fs_prev & ~bus1.pcm_fs;
    rose    = ~fs_prev & bus1.pcm_fs;
    tog     = fell | rose;
    fs_prev = bus1.pcm_fs;
    stb2    = bus2.sample_stb;
    stb_cnt += int'(bus1.sample_stb);
    if (glitch) bus1.pcm_in = ~bus1.pcm_in;
  endtask

  task automatic wait_fall(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!fell && n < 3000);
    if (!fell) timeout(nm);
  endtask

  task automatic wait_rise(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!rose && n < 3000);
    if (!rose) timeout(nm);
  endtask

  task automatic wait_tog(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!tog && n < 3000);
    if (!tog) timeout(nm);
  endtask

  task automatic wait_stb2(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!stb2 && n < 3000);
    if (!stb2) timeout(nm);
  endtask

  // Count toggles over W cycles starting right after a toggle; also the
  // shortest and longest phase seen.
  task automatic measure(input int w, output int toggles, output int pmin, output int pmax);
    int last = 0;
    toggles = 0; pmin = 1 << 30; pmax = 0;
    for (int j = 1; j <= w; j++) begin
      tick();
      if (tog) begin
        toggles++;
        if (j - last < pmin) pmin = j - last;
        if (j - last > pmax) pmax = j - last;
        last = j;
      end
    end
  endtask

  function automatic logic [23:0] conv(input logic [15:0] s, input int gs, input int ow);
    longint x, hi, lo;
    logic [63:0] y;
    x  = longint'($signed(s));
    x  = x * (longint'(1) << gs);
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) x = hi;
    else if (x < lo) x = lo;
    y = x;
    return y[23:0] & 24'((64'd1 << ow) - 1);
  endfunction

  // Falling event, then the load exactly one cycle later, strobe one cycle wide.
  task automatic cap_check(input string nm, input logic [47:0] exp);
    wait_rise(nm);
    wait_fall(nm);
    chk({nm, " stb@fall"}, 64'(bus1.sample_stb), 64'd0);
    tick();
    chk({nm, " stb"}, 64'(bus1.sample_stb), 64'd1);
    chk({nm, " pcm_out"}, 64'(bus1.pcm_out), 64'(exp));
    tick();
    chk({nm, " stb width"}, 64'(bus1.sample_stb), 64'd0);
  endtask

  initial begin
    int tg, pmin, pmax, early;
    logic [15:0] v0, v1;
    logic [47:0] hold;
    bit m;

    tbl[0] = '{16'h4000, 16'hA000, 16'h7FFF, 16'h8000};
    tbl[1] = '{16'h0100, 16'hFF00, 16'h0400, 16'hFC00};
    tbl[2] = '{16'h1FFF, 16'hE000, 16'h7FFC, 16'h8000};
    tbl[3] = '{16'h2000, 16'hDFFF, 16'h7FFF, 16'h8000};
    tbl[4] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFC};

    rst = 1'b1; rate_sel = 2'd0; mute = 1'b0; rate_sel2 = 2'd0; mute2 = 1'b0;
    bus1.pcm_in = '0; bus2.pcm_in = '0;
    #55;
    chk("reset pcm_fs", 64'(bus1.pcm_fs), 64'd0);
    chk("reset pcm_out", 64'(bus1.pcm_out), 64'd0);
    chk("reset stb", 64'(bus1.sample_stb), 64'd0);
    chk("reset rate_cur", 64'(rate_cur), 64'd0);
    chk("reset rate_err", 64'(rate_err), 64'd0);
    chk("reset miss", 64'(capture_miss), 64'd0);
    @(negedge pixel_clk);
    rst = 1'b0;

    // Rate 0 pacing
    wait_tog("r0 first toggle");
    measure(25000, tg, pmin, pmax);
    chk("r0 toggles", 64'(tg), 64'(25000 * 8 / 3125));
    chk("r0 phase min", 64'(pmin), 64'(3125 / 8));
    chk("r0 phase max", 64'(pmax), 64'(3125 / 8 + 1));

    // Default conversion
    bus1.pcm_in = {16'h7FFF, 16'h8000};
    cap_check("cap default", 48'h0FFFE0_F00000);

    // Input changing through an entire low phase
    wait_rise("glitch align");
    glitch = 1'b1;
    stb_cnt = 0;
    wait_fall("glitch fall");
    wait_rise("glitch rise");
    glitch = 1'b0;
    chk("glitch no stb", 64'(stb_cnt), 64'd0);
    chk("glitch hold", 64'(bus1.pcm_out), 64'h0FFFE0_F00000);
    chk("glitch miss", 64'(capture_miss), 64'd1);
    bus1.pcm_in = {16'hFEDC, 16'h1234};
    cap_check("cap after glitch", {conv(16'hFEDC, 5, 24), conv(16'h1234, 5, 24)});

    // Saturating variant from the vector table
    wait_stb2("sat align");
    for (int i = 0; i < 5; i++) begin
      bus2.pcm_in = {tbl[i].i1, tbl[i].i0};
      wait_stb2($sformatf("sat vec%0d", i));
      chk($sformatf("sat vec%0d", i), 64'(bus2.pcm_out), 64'({tbl[i].e1, tbl[i].e0}));
    end

    // Rate change requested mid-high-phase
    wait_rise("r1 align");
    repeat (100) tick();
    rate_sel = 2'd1;
    early = 0;
    begin
      int n = 0;
      do begin
        tick(); n++;
        if (!fell && rate_cur != 2'd0) early = 1;
      end while (!fell && n < 3000);
      if (!fell) timeout("r1 fall");
    end
    chk("r1 held until fall", 64'(early), 64'd0);
    chk("r1 rate_cur", 64'(rate_cur), 64'd1);
    wait_tog("r1 skip");
    measure(12500, tg, pmin, pmax);
    chk("r1 toggles", 64'(tg), 64'(12500 * 441 / 125000));

    rate_sel = 2'd2;
    wait_fall("r2 fall");
    chk("r2 rate_cur", 64'(rate_cur), 64'd2);
    wait_tog("r2 skip");
    measure(6250, tg, pmin, pmax);
    chk("r2 toggles", 64'(tg), 64'(6250 * 12 / 3125));

    // Illegal rate index
    rate_sel = 2'd3;
    wait_fall("rerr fall");
    wait_fall("rerr fall2");
    chk("rate_err", 64'(rate_err), 64'd1);
    chk("rate_err rate_cur", 64'(rate_cur), 64'd2);
    rate_sel = 2'd2;

    // Mute
    mute = 1'b1;
    bus1.pcm_in = {16'h5555, 16'h1111};
    cap_check("mute", 48'd0);
    mute = 1'b0;

    // Randomised captures against the conversion model
    for (int i = 0; i < 10; i++) begin
      v0 = 16'($urandom);
      v1 = 16'($urandom);
      m  = ($urandom_range(0, 3) == 0);
      mute = m;
      bus1.pcm_in = {v1, v0};
      hold = m ? 48'd0 : {conv(v1, 5, 24), conv(v0, 5, 24)};
      cap_check($sformatf("rand%0d", i), hold);
    end
    mute = 1'b0;

    // Asynchronous reset while a capture is pending
    bus1.pcm_in = {16'h0001, 16'h0001};
    cap_check("pre-reset", {24'h000020, 24'h000020});
    wait_rise("rst align");
    glitch = 1'b1;
    wait_fall("rst fall");
    tick();
    glitch = 1'b0;
    #5 rst = 1'b1;
    #1;
    chk("async pcm_fs", 64'(bus1.pcm_fs), 64'd0);
    chk("async pcm_out", 64'(bus1.pcm_out), 64'd0);
    chk("async stb", 64'(bus1.sample_stb), 64'd0);
    chk("async rate_cur", 64'(rate_cur), 64'd0);
    chk("async rate_err", 64'(rate_err), 64'd0);
    chk("async miss", 64'(capture_miss), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
